// File: rtl/mult_booth_seq.sv
// Sequential signed radix-2 Booth multiplier controller.
// Drives an external 32-bit adder one add/sub per clock.
module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_s,
  input  logic             adder_cout,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  logic [1:0]       pair;
  logic             ext;
  logic [WIDTH-1:0] sh_hi;
  logic [WIDTH-1:0] sh_lo;

  assign pair = {plo_q[0], qm1_q};

  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state_q == S_ITER) begin
      adder_a = phi_q;
      unique case (pair)
        2'b01: adder_b = m_q;
        2'b10: begin
          adder_b   = ~m_q;
          adder_cin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bit 32 of the sign-extended sum; exact even for M = -2^31.
  assign ext   = adder_a[WIDTH-1] ^ adder_b[WIDTH-1] ^ adder_cout;
  assign sh_hi = {ext, adder_s[WIDTH-1:1]};
  assign sh_lo = {adder_s[0], plo_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_start) begin
          m_d     = data_a;
          phi_d   = '0;
          plo_d   = data_b;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        phi_d = sh_hi;
        plo_d = sh_lo;
        qm1_d = plo_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d   = sh_lo;
          exc_d   = (sh_hi != {WIDTH{sh_lo[WIDTH-1]}});
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Sequential signed 32x32 multiplier controller.
- Computes the product with radix-2 Booth recoding, one iteration per clock.
- Owns no adder of its own. Each cycle it drives one add or subtract through an externally instantiated 32-bit carry-select adder (csa_32_bit).
- Sits beside the ALU as the multi-cycle multiply unit; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width. Must match the attached adder; only 32 is supported.
- CNT_W, 6, iteration counter width. Must hold the value WIDTH.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; forces IDLE on the next rising edge
- ctrl_start  input  1  request a multiply; sampled only in IDLE
- data_a  input  32  multiplicand, signed two's complement
- data_b  input  32  multiplier, signed two's complement
- adder_a  output  32  adder operand A (accumulator high half)
- adder_b  output  32  adder operand B (0, M, or ~M)
- adder_cin  output  1  adder carry-in (1 only for subtract)
- adder_s  input  32  adder sum, combinational from adder_a/adder_b/adder_cin
- adder_cout  input  1  adder carry-out
- data_result  output  32  low 32 bits of product
- data_exception  output  1  product not representable in 32 signed bits
- data_resultRDY  output  1  one-cycle pulse; result/exception valid
- busy  output  1  high from the cycle after start acceptance through the DONE cycle

Behaviour:
- Registers:
  - M[31:0]: latched multiplicand.
  - P_hi[31:0], P_lo[31:0], q_m1: Booth product register.
  - cnt[CNT_W-1:0].
  - State in {IDLE, ITER, DONE}.
- Reset (synchronous):
  - state=IDLE, all registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset overrides all other events, including mid-ITER and in DONE. No RDY is issued for an aborted operation.
- IDLE:
  - busy=0.
  - On ctrl_start=1: M<=data_a, P_hi<=0, P_lo<=data_b, q_m1<=0, cnt<=0, go to ITER.
  - ctrl_start=0: stay.
- ITER (busy=1): let pair={P_lo[0], q_m1}. Adder drive is combinational from state:
  - 00 or 11: adder_b=0, cin=0.
  - 01: adder_b=M, cin=0.
  - 10: adder_b=~M, cin=1.
  - adder_a=P_hi in every case. In IDLE and DONE: adder_a=adder_b=0, cin=0.
- ITER, per cycle:
  - ext = adder_a[31] ^ adder_b[31] ^ adder_cout. This is the true bit 32 of the sign-extended sum, so M=0x80000000 needs no special case.
  - Arithmetic shift right: {P_hi, P_lo, q_m1} <= {ext, adder_s, P_lo}.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 (the 32nd iteration), go to DONE.
- DONE (busy=1), for exactly one cycle:
  - data_resultRDY=1.
  - data_result=P_lo (registered output, held until the next DONE or reset).
  - data_exception = (P_hi != {32{P_lo[31]}}), also held.
  - Then go to IDLE.
- Latency:
  - ctrl_start sampled at edge k.
  - ITER occupies cycles k+1..k+32; DONE (RDY high) is cycle k+33.
  - Next start is accepted at edge k+34 at earliest.
- Operand capture: ctrl_start in ITER or DONE is ignored and not queued. data_a/data_b may change freely after the accepting edge.
- Zero operands: the full 32 iterations still execute (fixed latency).
- Adder is assumed purely combinational; no adder stall/handshake.
- Outputs data_result/data_exception change only at DONE entry or reset.

Test Plan:
- Basic multiply: reset 2 cycles, start with a=3, b=5 -> busy high 33 cycles; RDY pulse exactly 33 cycles after start edge; result=0x0000000F, exception=0.
- Signed operands: a=-7 (0xFFFFFFF9), b=6 -> result=0xFFFFFFD6, exception=0. Then a=-7, b=-6 -> result=0x0000002A, exception=0.
- Minimum-value multiplicand: a=0x80000000, b=1 -> result=0x80000000, exception=0. Then a=0x80000000, b=-1 -> result=0x80000000, exception=1. Checks the ext bit on subtract of M=-2^31.
- Overflow: a=0x00010000, b=0x00010000 -> result=0x00000000, exception=1. Also a=0x7FFFFFFF, b=2 -> result=0xFFFFFFFE, exception=1.
- Start ignored while busy: start a=2, b=3; pulse ctrl_start with a=9, b=9 at cycle 10 and in DONE -> single RDY with result=6; no second RDY without a new start in IDLE.
- Reset mid-operation: start a=5, b=5; assert reset at ITER cycle 10 -> next edge busy=0, result=0, no RDY. A new start then gives 25 after 33 cycles.
- Scoreboard: random 1000 operand pairs compared against the 64-bit signed reference product for both result and exception; adder_b/adder_cin checked against the Booth pair every ITER cycle.
